// File: rtl/ram_sp_master_if.sv
// Request/response channel between a client and ram_sp_master.
// master: the client side (CPU LSU, DMA). slave: the ram_sp_master side.
interface ram_sp_master_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 8
) ();
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_we;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_we, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_we, rsp_rdata
  );
endinterface

// File: rtl/ram_sp_master.sv
// ram_sp_master: sequences the strobes of one single-port synchronous RAM
// for read/write requests arriving on a valid/ready channel, and returns
// read data on a valid/ready response channel. All outputs are registered.
// Optional build macro RAM_MASTER_WRITE_ACK_EN: writes also return a
// response (rsp_we=1, rsp_rdata=0); without it writes complete silently.
//
// state | meaning
// IDLE  | req_ready high, waiting for a request handshake
// WR    | write strobes active, master drives ram_data
// RD_A  | read strobes active, RAM registers its read word
// RD_D  | RAM drives the bus, word captured on the closing edge
// RSP   | response held until rsp_ready
module ram_sp_master #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  ram_sp_master_if.slave        bus,
  output logic [ADDR_WIDTH-1:0] ram_address,
  inout  wire  [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe
);

  typedef enum logic [2:0] {IDLE, WR, RD_A, RD_D, RSP} state_t;

  state_t                state_q, state_n;
  logic                  req_ready_q, req_ready_n;
  logic                  rsp_valid_q, rsp_valid_n;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic                  cs_n, we_n, oe_n;
  logic                  drive_q, drive_n;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_n;
`ifdef RAM_MASTER_WRITE_ACK_EN
  logic                  rsp_we_q, rsp_we_n;
`endif

  // Master drives the bus only while the write-drive flag is set.
  assign ram_data      = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};
  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
`ifdef RAM_MASTER_WRITE_ACK_EN
  assign bus.rsp_we    = rsp_we_q;
`else
  assign bus.rsp_we    = 1'b0;
`endif

  // State and all registered outputs; reset forces everything idle at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      ram_address <= '0;
      ram_cs      <= 1'b0;
      ram_we      <= 1'b0;
      ram_oe      <= 1'b0;
      drive_q     <= 1'b0;
      wdata_q     <= '0;
`ifdef RAM_MASTER_WRITE_ACK_EN
      rsp_we_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_n;
      req_ready_q <= req_ready_n;
      rsp_valid_q <= rsp_valid_n;
      rsp_rdata_q <= rsp_rdata_n;
      ram_address <= addr_n;
      ram_cs      <= cs_n;
      ram_we      <= we_n;
      ram_oe      <= oe_n;
      drive_q     <= drive_n;
      wdata_q     <= wdata_n;
`ifdef RAM_MASTER_WRITE_ACK_EN
      rsp_we_q    <= rsp_we_n;
`endif
    end
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_n     = state_q;
    req_ready_n = req_ready_q;
    rsp_valid_n = rsp_valid_q;
    rsp_rdata_n = rsp_rdata_q;
    addr_n      = ram_address;
    cs_n        = ram_cs;
    we_n        = ram_we;
    oe_n        = ram_oe;
    drive_n     = drive_q;
    wdata_n     = wdata_q;
`ifdef RAM_MASTER_WRITE_ACK_EN
    rsp_we_n    = rsp_we_q;
`endif
    case (state_q)
      IDLE: begin
        req_ready_n = 1'b1;
        if (bus.req_valid && req_ready_q) begin
          req_ready_n = 1'b0;
          addr_n      = bus.req_addr;
          wdata_n     = bus.req_wdata;
          cs_n        = 1'b1;
          if (bus.req_we) begin
            we_n    = 1'b1;
            oe_n    = 1'b0;
            drive_n = 1'b1;
            state_n = WR;
          end else begin
            we_n    = 1'b0;
            oe_n    = 1'b1;
            drive_n = 1'b0;
            state_n = RD_A;
          end
        end
      end
      WR: begin
        cs_n    = 1'b0;
        we_n    = 1'b0;
        drive_n = 1'b0;
`ifdef RAM_MASTER_WRITE_ACK_EN
        rsp_valid_n = 1'b1;
        rsp_we_n    = 1'b1;
        rsp_rdata_n = '0;
        state_n     = RSP;
`else
        req_ready_n = 1'b1;
        state_n     = IDLE;
`endif
      end
      RD_A: begin
        state_n = RD_D;
      end
      RD_D: begin
        rsp_rdata_n = ram_data;
        rsp_valid_n = 1'b1;
`ifdef RAM_MASTER_WRITE_ACK_EN
        rsp_we_n    = 1'b0;
`endif
        cs_n        = 1'b0;
        oe_n        = 1'b0;
        state_n     = RSP;
      end
      RSP: begin
        if (bus.rsp_ready) begin
          rsp_valid_n = 1'b0;
          req_ready_n = 1'b1;
          state_n     = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ram_sp_master.sv
module tb_ram_sp_master;

`ifdef RAM_MASTER_WRITE_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  ram_address;
  wire  [63:0] ram_data;
  logic        ram_cs, ram_we, ram_oe;
  int          cyc = 0;

  ram_sp_master_if #(.DATA_WIDTH(64), .ADDR_WIDTH(8)) bus ();

  ram_sp_master #(.DATA_WIDTH(64), .ADDR_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .ram_address(ram_address), .ram_data(ram_data),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port synchronous RAM.
  logic [63:0] mem [256];
  logic [63:0] ram_q = '0;
  always @(posedge clk) begin
    if (ram_cs && ram_we) mem[ram_address] <= ram_data;
    else if (ram_cs) ram_q <= mem[ram_address];
  end
  assign ram_data = (ram_oe && !ram_we) ? ram_q : {64{1'bz}};

  typedef struct { logic we; logic [7:0] addr; logic [63:0] wdata; logic [63:0] exp; } vec_t;
  typedef struct { logic we; logic [63:0] rdata; } rsp_t;

  vec_t vecs[9];
  rsp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    rsp_t e;
    forever begin
      @(negedge clk);
      if (!reset && bus.rsp_valid && bus.rsp_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", {63'd0, bus.rsp_valid}, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("rsp_we", {63'd0, bus.rsp_we}, {63'd0, e.we});
          chk("rsp_rdata", bus.rsp_rdata, e.rdata);
        end
      end
    end
  endtask

  // Presents a request (called just after a rising edge) and returns the
  // cycle index of the accepting edge. req_valid is left high.
  task automatic do_req(input logic we, input logic [7:0] a, input logic [63:0] d,
                        input logic [63:0] exp, output int acc);
    bit got = 0;
    rsp_t e;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    for (int b = 0; b < 60 && !got; b++) begin
      @(negedge clk);
      if (bus.req_ready) got = 1;
      @(posedge clk); #1;
    end
    acc = cyc;
    if (!got) begin
      chk("req_accept_timeout", 64'd0, 64'd1);
    end else if (!we) begin
      e.we = 1'b0; e.rdata = exp; sb.push_back(e);
    end else if (ACK) begin
      e.we = 1'b1; e.rdata = '0; sb.push_back(e);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int acc, a0, a1, a2, k;
    vecs[0] = '{1'b1, 8'h10, 64'hDEADBEEF_01234567, 64'h0};
    vecs[1] = '{1'b0, 8'h10, 64'h0, 64'hDEADBEEF_01234567};
    vecs[2] = '{1'b1, 8'hFF, 64'h1111_2222_3333_4444, 64'h0};
    vecs[3] = '{1'b1, 8'h00, 64'h5555_6666_7777_8888, 64'h0};
    vecs[4] = '{1'b0, 8'hFF, 64'h0, 64'h1111_2222_3333_4444};
    vecs[5] = '{1'b0, 8'h00, 64'h0, 64'h5555_6666_7777_8888};
    vecs[6] = '{1'b0, 8'h10, 64'h0, 64'hDEADBEEF_01234567};
    vecs[7] = '{1'b1, 8'h80, 64'hA5A5_5A5A_0F0F_F0F0, 64'h0};
    vecs[8] = '{1'b0, 8'h80, 64'h0, 64'hA5A5_5A5A_0F0F_F0F0};

    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.rsp_ready = 1'b1;
    fork monitor(); join_none
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctl", {58'd0, bus.req_ready, bus.rsp_valid, bus.rsp_we, ram_cs, ram_we, ram_oe}, 64'd0);
    chk("reset_addr", {56'd0, ram_address}, 64'd0);
    chk("reset_rdata", bus.rsp_rdata, 64'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_reset", {63'd0, bus.req_ready}, 64'd1);

    // Table: writes then read-backs, including both address extremes.
    foreach (vecs[i]) do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp, acc);
    bus.req_valid = 1'b0;
    drain();

    // Write strobe pattern and bus drive.
    do_req(1'b1, 8'h33, 64'hCAFEF00D_55AA55AA, 64'h0, acc);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("wr_strobes", {61'd0, ram_cs, ram_we, ram_oe}, 64'b110);
    chk("wr_addr", {56'd0, ram_address}, 64'h33);
    chk("wr_bus", ram_data, 64'hCAFEF00D_55AA55AA);
    @(negedge clk);
    chk("wr_after", {58'd0, ram_cs, ram_we, ram_oe, bus.rsp_valid, bus.rsp_we, bus.req_ready},
        {58'd0, 3'b000, ACK, ACK, !ACK});
    drain();

    // Read latency: rsp_valid two edges after accept.
    @(posedge clk); #1;
    do_req(1'b0, 8'h33, 64'h0, 64'hCAFEF00D_55AA55AA, acc);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("rd_a_strobes", {61'd0, ram_cs, ram_we, ram_oe}, 64'b101);
    k = 0;
    while (!bus.rsp_valid && k < 10) begin @(negedge clk); k++; end
    chk("rd_latency", 64'(cyc - acc), 64'd2);
    drain();

    // Response stall for 5 cycles.
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    do_req(1'b0, 8'hFF, 64'h0, 64'h1111_2222_3333_4444, acc);
    bus.req_valid = 1'b0;
    k = 0;
    while (!bus.rsp_valid && k < 10) begin @(negedge clk); k++; end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_hold", {60'd0, bus.rsp_valid, bus.req_ready, ram_cs, ram_oe}, 64'b1000);
      chk("stall_rdata", bus.rsp_rdata, 64'h1111_2222_3333_4444);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    drain();

    // Back-to-back write/read/write with req_valid held high.
    @(posedge clk); #1;
    do_req(1'b1, 8'h40, 64'h0123_4567_89AB_CDEF, 64'h0, a0);
    do_req(1'b0, 8'h40, 64'h0, 64'h0123_4567_89AB_CDEF, a1);
    do_req(1'b1, 8'h41, 64'hFEDC_BA98_7654_3210, 64'h0, a2);
    bus.req_valid = 1'b0;
    chk("stream_gap1", 64'(a1 - a0), ACK ? 64'd3 : 64'd2);
    chk("stream_gap2", 64'(a2 - a1), 64'd4);
    drain();

    // Reset during RD_D discards the read; a fresh read afterwards works.
    @(posedge clk); #1;
    do_req(1'b0, 8'h00, 64'h0, 64'h5555_6666_7777_8888, acc);
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    sb.delete();
    chk("rst_mid_ctl", {58'd0, bus.req_ready, bus.rsp_valid, bus.rsp_we, ram_cs, ram_we, ram_oe}, 64'd0);
    chk("rst_mid_addr", {56'd0, ram_address}, 64'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_ready", {63'd0, bus.req_ready}, 64'd1);
    do_req(1'b0, 8'h41, 64'h0, 64'hFEDC_BA98_7654_3210, acc);
    bus.req_valid = 1'b0;
    drain();

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ram_sp_master.md
# ram_sp_master

Synchronous initiator for the team's single-port synchronous RAM (shared bidirectional data bus; chip-select, write-enable and output-enable strobes). It accepts read and write requests on a valid/ready request channel and sequences the RAM bus strobes. It returns read data on a valid/ready response channel. It sits between any client (CPU load/store unit, DMA) and one RAM instance, and is the only driver of that RAM's control pins.

## Interface
- DATA_WIDTH, 64, RAM word width
- ADDR_WIDTH, 8, RAM address width
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request
- req_we  input  1  1 = write, 0 = read
- req_addr  input  ADDR_WIDTH  request address
- req_wdata  input  DATA_WIDTH  write data
- rsp_valid  output  1  response present
- rsp_ready  input  1  client accepts response
- rsp_we  output  1  0 = read data response, 1 = write acknowledge
- rsp_rdata  output  DATA_WIDTH  read data
- ram_address  output  ADDR_WIDTH  RAM address
- ram_data  inout  DATA_WIDTH  RAM data bus
- ram_cs  output  1  RAM chip select
- ram_we  output  1  RAM write enable
- ram_oe  output  1  RAM output enable

## Operation
- All outputs are registered. ram_data is driven only when the internal write-drive flag is set; otherwise it is hi-Z.
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_we=0, rsp_rdata=0
  - ram_address=0, ram_cs=0, ram_we=0, ram_oe=0
  - ram_data hi-Z, state IDLE
- req_ready rises on the first clk edge after reset deasserts.
- FSM states: IDLE, WR, RD_A, RD_D, RSP.
- IDLE: req_ready=1. A handshake (req_valid & req_ready) at an edge latches addr/we/wdata and drops req_ready.
  - If req_we=1: next state WR.
  - If req_we=0: next state RD_A.
- WR (1 cycle):
  - Drives ram_address, ram_cs=1, ram_we=1, ram_oe=0, ram_data=wdata.
  - The RAM writes on the closing edge.
  - Next state is IDLE; under WRITE_ACK (see Configuration) it is RSP with rsp_we=1.
- RD_A (1 cycle): drives ram_cs=1, ram_we=0, ram_oe=1, ram_data hi-Z. The RAM registers its read word on the closing edge.
- RD_D (1 cycle):
  - Strobes are held so the RAM drives the bus.
  - On the closing edge: rsp_rdata <= ram_data, rsp_valid=1, rsp_we=0.
  - All strobes deassert; next state is RSP.
- RSP: rsp_valid and rsp_rdata are held stable until rsp_ready=1 at an edge. Then rsp_valid=0, req_ready=1, next state IDLE.
- The bus is never driven by both ends. The master drives ram_data only when ram_oe=0, and the RAM drives only when ram_oe=1 & ~ram_we.
- ram_address changes only on a request handshake and is held between requests. Any address value 0..2^ADDR_WIDTH-1 is legal; there is no wrap logic.
- Only one request is outstanding at a time. req_valid while req_ready=0 is ignored and must be held by the client.

## Timing
- Request accepted at edge N. Read: ram_cs high in cycles N..N+2, rsp_valid high from edge N+2.
- Earliest next accept is edge N+4 (rsp_ready=1 at edge N+3).
- Write without ack: strobes active between edges N and N+1, req_ready=1 after N+1. Earliest next accept is edge N+2.
- Write with ack: rsp_valid high from edge N+1. Earliest next accept is edge N+3.
- rsp_ready held low stalls indefinitely in RSP; the RAM bus stays idle during a stall.
- Reset asserted in any state: all outputs take their reset values asynchronously.
  - ram_cs/ram_we drop at once, and the bus is released.
  - An in-flight write may or may not have landed; an in-flight read response is discarded.

## Configuration
- RAM_MASTER_WRITE_ACK_EN defined: every write also produces a response (rsp_valid=1, rsp_we=1, rsp_rdata=0) after WR and waits in RSP for rsp_ready.
- Undefined: writes complete silently, and WR returns directly to IDLE. rsp_we is a constant 0.

## Test plan
- Write addr 0x10 data 0xDEADBEEF_01234567, then read 0x10 -> rsp_rdata=0xDEADBEEF_01234567, rsp_valid rises 2 edges after read accept.
- Read with rsp_ready low 5 cycles -> rsp_valid/rsp_rdata stable for 5 cycles, req_ready=0, ram_cs=0 throughout; accept on release.
- Write addr 0xFF then addr 0x00 with distinct data, read both back -> correct data for both, no aliasing; bus never driven by both ends (no X on ram_data).
- Back-to-back write/read/write stream with req_valid held high -> accepts at N, N+2, N+6; strobe pattern matches Operation exactly.
- Assert reset during RD_D -> outputs go to reset values immediately, no rsp_valid; after release, req_ready=1 on the next edge and a fresh read returns correct data.
- With RAM_MASTER_WRITE_ACK_EN: write addr 0x20 -> rsp_valid=1, rsp_we=1 from edge N+1, rsp_rdata=0; without it, no rsp_valid for writes.
